split_eval_seq: RTL and testbench

SPLIT_EVAL_SEQ -- requirements
Module: split_eval_seq

---
 rtl/split_eval_seq_pkg.sv | 17 +
 rtl/split_eval_seq_pred.sv | 30 +++
 rtl/split_eval_seq.sv | 101 ++++++++++
 tb/tb_split_eval_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/split_eval_seq_pkg.sv
// Shared types and constants for the split evaluation sequencer.
package split_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FINISH  = 2'd2
    } state_e;

    localparam int PRED_TRUE     = 0;
    localparam int PRED_NONZERO  = 1;
    localparam int PRED_LE_LIMIT = 2;

    localparam int DEF_NUM_VARS = 150;
    localparam int DEF_VAR_W    = 16;

endpackage

// File: rtl/split_eval_seq_pred.sv
// Combinational width mask plus per-variable predicate for the split sequencer.
module split_pred
    import split_pkg::*;
#(
    parameter int              VAR_W = DEF_VAR_W,
    parameter int              MODE  = PRED_TRUE,
    parameter logic [VAR_W-1:0] LIMIT = '0
) (
    input  logic [VAR_W-1:0]           var_data,
    input  logic [$clog2(VAR_W+1)-1:0] var_width,
    output logic                       pass
);

    logic [VAR_W-1:0] mask;
    logic [VAR_W-1:0] masked;

    always_comb begin
        // A shift by VAR_W or more yields zero, so full width means no masking.
        mask   = ~({VAR_W{1'b1}} << var_width);
        masked = var_data & mask;
        if (MODE == PRED_NONZERO) begin
            pass = |masked;
        end else if (MODE == PRED_LE_LIMIT) begin
            pass = (masked <= LIMIT);
        end else begin
            pass = 1'b1;
        end
    end

endmodule

// File: rtl/split_eval_seq.sv
// Collects NUM_VARS variable words after a start request and reports the AND
// of a per-word predicate as the split result x, with a one-cycle done pulse.
module split_eval_seq
    import split_pkg::*;
#(
    parameter int               NUM_VARS = DEF_NUM_VARS,
    parameter int               VAR_W    = DEF_VAR_W,
    parameter int               MODE     = PRED_TRUE,
    parameter logic [VAR_W-1:0] LIMIT    = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          var_valid,
    input  logic [VAR_W-1:0]              var_data,
    input  logic [$clog2(VAR_W+1)-1:0]    var_width,
    output logic                          var_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          x,
    output logic [$clog2(NUM_VARS+1)-1:0] count
);

    localparam int              CNT_W = $clog2(NUM_VARS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_VARS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               acc_q, acc_d;
    logic               x_q, x_d;
    logic               done_q, done_d;
    logic               pass;

    split_pred #(
        .VAR_W (VAR_W),
        .MODE  (MODE),
        .LIMIT (LIMIT)
    ) u_pred (
        .var_data  (var_data),
        .var_width (var_width),
        .pass      (pass)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        x_d     = x_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COLLECT;
                    count_d = '0;
                    acc_d   = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (var_valid) begin
                    acc_d   = acc_q & pass;
                    count_d = count_q + CNT_W'(1);
                    // Result and done are registered together so x is valid while done is high.
                    if (count_q == LAST) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        x_d     = acc_q & pass;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            acc_q   <= 1'b1;
            x_q     <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            done_q  <= done_d;
        end
    end

    assign var_ready = (state_q == ST_COLLECT);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign x         = x_q;
    assign count     = count_q;

endmodule

// File: tb/tb_split_eval_seq.sv
// Directed bench for split_eval_seq: three configurations exercising TRUE,
// NONZERO (with width masking) and LE_LIMIT predicates.
module tb_split_eval_seq;
    import split_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        st0 = 1'b0, vv0 = 1'b0;
    logic [15:0] vd0 = '0;
    logic [4:0]  vw0 = 5'd16;
    logic        rdy0, busy0, done0, x0;
    logic [2:0]  cnt0;

    logic        st1 = 1'b0, vv1 = 1'b0;
    logic [15:0] vd1 = '0;
    logic [4:0]  vw1 = 5'd16;
    logic        rdy1, busy1, done1, x1;
    logic [2:0]  cnt1;

    logic        st2 = 1'b0, vv2 = 1'b0;
    logic [15:0] vd2 = '0;
    logic [4:0]  vw2 = 5'd16;
    logic        rdy2, busy2, done2, x2;
    logic [1:0]  cnt2;

    int n_chk = 0;
    int n_fail = 0;
    int dc0 = 0, dc1 = 0, dc2 = 0;

    split_eval_seq #(.NUM_VARS(4), .VAR_W(16), .MODE(PRED_TRUE), .LIMIT(16'd0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .var_valid(vv0), .var_data(vd0), .var_width(vw0),
        .var_ready(rdy0), .busy(busy0), .done(done0), .x(x0), .count(cnt0));

    split_eval_seq #(.NUM_VARS(4), .VAR_W(16), .MODE(PRED_NONZERO), .LIMIT(16'd0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .var_valid(vv1), .var_data(vd1), .var_width(vw1),
        .var_ready(rdy1), .busy(busy1), .done(done1), .x(x1), .count(cnt1));

    split_eval_seq #(.NUM_VARS(3), .VAR_W(16), .MODE(PRED_LE_LIMIT), .LIMIT(16'd100)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .var_valid(vv2), .var_data(vd2), .var_width(vw2),
        .var_ready(rdy2), .busy(busy2), .done(done2), .x(x2), .count(cnt2));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done0) dc0++;
        if (done1) dc1++;
        if (done2) dc2++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start0; st0 = 1'b1; tick(); st0 = 1'b0; endtask
    task automatic start1; st1 = 1'b1; tick(); st1 = 1'b0; endtask
    task automatic start2; st2 = 1'b1; tick(); st2 = 1'b0; endtask

    task automatic xfer0(input logic [15:0] d, input logic [4:0] w);
        logic pre;
        bit   ok;
        ok = 0;
        vd0 = d; vw0 = w; vv0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pre = rdy0;
            tick();
            if (pre) begin ok = 1; break; end
        end
        vv0 = 1'b0;
        if (!ok) begin n_chk++; n_fail++; $display("FAIL xfer0_timeout: ready=0 required 1"); end
    endtask

    task automatic xfer1(input logic [15:0] d, input logic [4:0] w);
        logic pre;
        bit   ok;
        ok = 0;
        vd1 = d; vw1 = w; vv1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pre = rdy1;
            tick();
            if (pre) begin ok = 1; break; end
        end
        vv1 = 1'b0;
        if (!ok) begin n_chk++; n_fail++; $display("FAIL xfer1_timeout: ready=0 required 1"); end
    endtask

    task automatic xfer2(input logic [15:0] d, input logic [4:0] w);
        logic pre;
        bit   ok;
        ok = 0;
        vd2 = d; vw2 = w; vv2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pre = rdy2;
            tick();
            if (pre) begin ok = 1; break; end
        end
        vv2 = 1'b0;
        if (!ok) begin n_chk++; n_fail++; $display("FAIL xfer2_timeout: ready=0 required 1"); end
    endtask

    task automatic test_reset;
        #12;
        n_chk++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", rdy0); end
        n_chk++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy0); end
        n_chk++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done0); end
        n_chk++; if (x0 !== 1'b1) begin n_fail++; $display("FAIL rst_x: got %b want 1", x0); end
        n_chk++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", cnt0); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_chk++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL rst_idle_after_release: busy=%b want 0", busy2); end
    endtask

    task automatic test_mode0_back_to_back;
        int base;
        base = dc0;
        start0();
        n_chk++; if (busy0 !== 1'b1 || rdy0 !== 1'b1) begin n_fail++; $display("FAIL m0_collect: busy=%b ready=%b want 1 1", busy0, rdy0); end
        n_chk++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL m0_count_clear: got %0d want 0", cnt0); end
        repeat (4) xfer0(16'h0000, 5'd16);
        n_chk++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL m0_done: got %b want 1", done0); end
        n_chk++; if (x0 !== 1'b1) begin n_fail++; $display("FAIL m0_x: got %b want 1", x0); end
        n_chk++; if (cnt0 !== 3'd4) begin n_fail++; $display("FAIL m0_count: got %0d want 4", cnt0); end
        n_chk++; if (rdy0 !== 1'b0 || busy0 !== 1'b1) begin n_fail++; $display("FAIL m0_finish: ready=%b busy=%b want 0 1", rdy0, busy0); end
        tick();
        n_chk++; if (done0 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL m0_idle: done=%b busy=%b want 0 0", done0, busy0); end
        n_chk++; if (dc0 - base !== 1) begin n_fail++; $display("FAIL m0_done_pulses: got %0d want 1", dc0 - base); end
        vv0 = 1'b1; vd0 = 16'h1234;
        tick(); tick();
        vv0 = 1'b0;
        n_chk++; if (cnt0 !== 3'd4 || busy0 !== 1'b0) begin n_fail++; $display("FAIL m0_idle_drop: count=%0d busy=%b want 4 0", cnt0, busy0); end
    endtask

    task automatic test_mode1_mask;
        int base;
        base = dc1;
        start1();
        xfer1(16'h0003, 5'd4);
        xfer1(16'h0010, 5'd4);
        xfer1(16'h0000, 5'd4);
        xfer1(16'h0007, 5'd4);
        n_chk++; if (done1 !== 1'b1 || x1 !== 1'b0) begin n_fail++; $display("FAIL m1_mask_result: done=%b x=%b want 1 0", done1, x1); end
        n_chk++; if (cnt1 !== 3'd4) begin n_fail++; $display("FAIL m1_count: got %0d want 4", cnt1); end
        tick();
        n_chk++; if (dc1 - base !== 1) begin n_fail++; $display("FAIL m1_done_pulses: got %0d want 1", dc1 - base); end
        start1();
        n_chk++; if (x1 !== 1'b0 || cnt1 !== 3'd0) begin n_fail++; $display("FAIL m1_hold_at_start: x=%b count=%0d want 0 0", x1, cnt1); end
        xfer1(16'h0001, 5'd16);
        xfer1(16'h00F3, 5'd4);
        xfer1(16'h8000, 5'd16);
        xfer1(16'h0100, 5'd9);
        n_chk++; if (done1 !== 1'b1 || x1 !== 1'b1) begin n_fail++; $display("FAIL m1_all_nonzero: done=%b x=%b want 1 1", done1, x1); end
        tick();
    endtask

    task automatic test_gaps_extra;
        int base;
        logic [15:0] d;
        base = dc2;
        start2();
        for (int i = 1; i <= 3; i++) begin
            repeat ($urandom_range(3, 0)) tick();
            d = 16'(i);
            xfer2(d, 5'd16);
        end
        n_chk++; if (done2 !== 1'b1 || x2 !== 1'b1 || cnt2 !== 2'd3) begin n_fail++; $display("FAIL gap_result: done=%b x=%b count=%0d want 1 1 3", done2, x2, cnt2); end
        vv2 = 1'b1; vd2 = 16'd7;
        tick(); tick(); tick();
        vv2 = 1'b0;
        n_chk++; if (cnt2 !== 2'd3 || busy2 !== 1'b0) begin n_fail++; $display("FAIL gap_extra_word: count=%0d busy=%b want 3 0", cnt2, busy2); end
        n_chk++; if (dc2 - base !== 1) begin n_fail++; $display("FAIL gap_done_pulses: got %0d want 1", dc2 - base); end
    endtask

    task automatic test_mode2_limit;
        start2();
        xfer2(16'd100, 5'd16);
        xfer2(16'd5, 5'd16);
        xfer2(16'd99, 5'd16);
        n_chk++; if (done2 !== 1'b1 || x2 !== 1'b1) begin n_fail++; $display("FAIL m2_at_limit: done=%b x=%b want 1 1", done2, x2); end
        tick();
        start2();
        xfer2(16'd101, 5'd16);
        xfer2(16'd5, 5'd16);
        xfer2(16'd99, 5'd16);
        n_chk++; if (done2 !== 1'b1 || x2 !== 1'b0) begin n_fail++; $display("FAIL m2_over_limit: done=%b x=%b want 1 0", done2, x2); end
        tick(); tick(); tick();
        n_chk++; if (x2 !== 1'b0 || cnt2 !== 2'd3) begin n_fail++; $display("FAIL m2_hold: x=%b count=%0d want 0 3", x2, cnt2); end
    endtask

    task automatic test_reset_mid;
        int base;
        start0();
        xfer0(16'h0001, 5'd16);
        xfer0(16'h0002, 5'd16);
        base = dc0;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (rdy0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: ready=%b busy=%b done=%b want 0 0 0", rdy0, busy0, done0); end
        n_chk++; if (cnt0 !== 3'd0 || x0 !== 1'b1) begin n_fail++; $display("FAIL midrst_data: count=%0d x=%b want 0 1", cnt0, x0); end
        n_chk++; if (x2 !== 1'b1 || cnt2 !== 2'd0) begin n_fail++; $display("FAIL midrst_other: x=%b count=%0d want 1 0", x2, cnt2); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick(); tick();
        n_chk++; if (busy0 !== 1'b0 || dc0 - base !== 0) begin n_fail++; $display("FAIL midrst_no_done: busy=%b pulses=%0d want 0 0", busy0, dc0 - base); end
        start0();
        repeat (4) xfer0(16'h00AA, 5'd16);
        n_chk++; if (done0 !== 1'b1 || cnt0 !== 3'd4 || x0 !== 1'b1) begin n_fail++; $display("FAIL midrst_restart: done=%b count=%0d x=%b want 1 4 1", done0, cnt0, x0); end
        tick();
    endtask

    task automatic test_start_mid;
        int base;
        base = dc0;
        start0();
        xfer0(16'h0001, 5'd16);
        st0 = 1'b1;
        xfer0(16'h0002, 5'd16);
        st0 = 1'b0;
        n_chk++; if (cnt0 !== 3'd2 || busy0 !== 1'b1) begin n_fail++; $display("FAIL startmid_count: count=%0d busy=%b want 2 1", cnt0, busy0); end
        xfer0(16'h0003, 5'd16);
        xfer0(16'h0004, 5'd16);
        n_chk++; if (done0 !== 1'b1 || cnt0 !== 3'd4) begin n_fail++; $display("FAIL startmid_done: done=%b count=%0d want 1 4", done0, cnt0); end
        tick(); tick();
        n_chk++; if (dc0 - base !== 1 || busy0 !== 1'b0) begin n_fail++; $display("FAIL startmid_single: pulses=%0d busy=%b want 1 0", dc0 - base, busy0); end
    endtask

    initial begin
        test_reset();
        test_mode0_back_to_back();
        test_mode1_mask();
        test_gaps_extra();
        test_mode2_limit();
        test_reset_mid();
        test_start_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
